dual_port_mem: RTL and testbench

//  True dual-port synchronous RAM with two independent read/write ports (A, B) on one clock.

---
 rtl/dual_port_mem.sv | 83 ++++++++
 tb/tb_dual_port_mem.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem.sv
// True dual-port synchronous RAM shared by two masters on one clock.
// Port A wins write-write conflicts at the same address. A read that meets a
// write to the same address returns the word stored before that write.
// The collision flag pulses for one cycle after each conflicting edge.
module dual_port_mem #(
    parameter int addrW = 8,
    parameter int dataW = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             EnA,
    input  logic             wEnA,
    input  logic [addrW-1:0] addrA,
    input  logic [dataW-1:0] dInA,
    output logic [dataW-1:0] dOutA,
    input  logic             EnB,
    input  logic             wEnB,
    input  logic [addrW-1:0] addrB,
    input  logic [dataW-1:0] dInB,
    output logic [dataW-1:0] dOutB,
    output logic             collision
);

    localparam int depth = 1 << addrW;

    logic [dataW-1:0] mem [depth];

    logic             wr_a;
    logic             wr_b;
    logic             rd_a;
    logic             rd_b;
    logic             wr_b_kept;
    logic             conflict;
    logic [dataW-1:0] dout_a_d;
    logic [dataW-1:0] dout_a_q;
    logic [dataW-1:0] dout_b_d;
    logic [dataW-1:0] dout_b_q;
    logic             collision_d;
    logic             collision_q;

    // Decode accesses, detect same-address conflicts and select next read data.
    // The array is read combinationally here, so the registered value is the
    // word present before this edge's writes (read-before-write).
    always_comb begin
        wr_a        = EnA & wEnA;
        wr_b        = EnB & wEnB;
        rd_a        = EnA & ~wEnA;
        rd_b        = EnB & ~wEnB;
        conflict    = EnA & EnB & (addrA == addrB) & (wEnA | wEnB);
        wr_b_kept   = wr_b & ~(wr_a & (addrA == addrB));
        dout_a_d    = rd_a ? mem[addrA] : dout_a_q;
        dout_b_d    = rd_b ? mem[addrB] : dout_b_q;
        collision_d = conflict;
    end

    // Array writes; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_b_kept) begin
            mem[addrB] <= dInB;
        end
        if (wr_a) begin
            mem[addrA] <= dInA;
        end
    end

    // Registered read data and collision flag, cleared asynchronously.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            collision_q <= collision_d;
        end
    end

    assign dOutA     = dout_a_q;
    assign dOutB     = dout_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Bench for dual_port_mem: a reference model predicts each edge's outputs,
// which are queued when stimulus is driven and popped after the edge.
module tb_dual_port_mem;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rstN;
    logic          EnA, wEnA, EnB, wEnB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dInA, dInB;
    logic [DW-1:0] dOutA, dOutB;
    logic          collision;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [1 << AW];
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic          exp_c_q[$];

    dual_port_mem #(.addrW(AW), .dataW(DW)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .EnA       (EnA),
        .wEnA      (wEnA),
        .addrA     (addrA),
        .dInA      (dInA),
        .dOutA     (dOutA),
        .EnB       (EnB),
        .wEnB      (wEnB),
        .addrB     (addrB),
        .dInB      (dInB),
        .dOutB     (dOutB),
        .collision (collision)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, compare after posedge.
    task automatic do_cycle(input logic ea, input logic wa, input logic [AW-1:0] aa,
                            input logic [DW-1:0] da, input logic eb, input logic wb,
                            input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic c;
        @(negedge clk);
        EnA = ea; wEnA = wa; addrA = aa; dInA = da;
        EnB = eb; wEnB = wb; addrB = ab; dInB = db;
        if (ea && !wa) exp_a = model[aa];
        if (eb && !wb) exp_b = model[ab];
        c = ea && eb && (aa == ab) && (wa || wb);
        if (eb && wb) model[ab] = db;
        if (ea && wa) model[aa] = da;
        exp_a_q.push_back(exp_a);
        exp_b_q.push_back(exp_b);
        exp_c_q.push_back(c);
        @(posedge clk);
        #1;
        check("dOutA", 32'(dOutA), 32'(exp_a_q.pop_front()));
        check("dOutB", 32'(dOutB), 32'(exp_b_q.pop_front()));
        check("collision", 32'(collision), 32'(exp_c_q.pop_front()));
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
    endtask

    initial begin
        // Reset
        rstN = 1'b0;
        EnA = 0; wEnA = 0; addrA = '0; dInA = '0;
        EnB = 0; wEnB = 0; addrB = '0; dInB = '0;
        exp_a = '0; exp_b = '0;
        #2;
        check("rst_dOutA", 32'(dOutA), 32'h0);
        check("rst_dOutB", 32'(dOutB), 32'h0);
        check("rst_collision", 32'(collision), 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Fill the whole array, both ports writing distinct addresses.
        for (int i = 0; i < (1 << AW) / 2; i++) begin
            do_cycle(1'b1, 1'b1, AW'(2 * i), DW'($urandom_range(0, 16'hffff)),
                     1'b1, 1'b1, AW'(2 * i + 1), DW'($urandom_range(0, 16'hffff)));
        end

        // 1: write then read on A
        do_cycle(1, 1, 8'h01, 16'h0002, 0, 0, 8'h00, 16'h0);
        do_cycle(1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0);
        check("t1_const", 32'(dOutA), 32'h0002);

        // 2: write on B, read back on B and cross-read on A
        do_cycle(0, 0, 8'h00, 16'h0, 1, 1, 8'h03, 16'h0004);
        do_cycle(1, 0, 8'h03, 16'h0, 1, 0, 8'h03, 16'h0);
        check("t2_const_b", 32'(dOutB), 32'h0004);
        check("t2_const_a", 32'(dOutA), 32'h0004);

        // 3: write-write conflict, A wins
        do_cycle(1, 1, 8'h05, 16'h0007, 1, 1, 8'h05, 16'h0008);
        check("t3_coll", 32'(collision), 32'h1);
        idle();
        do_cycle(1, 0, 8'h05, 16'h0, 1, 0, 8'h05, 16'h0);
        check("t3_const_a", 32'(dOutA), 32'h0007);
        check("t3_const_b", 32'(dOutB), 32'h0007);

        // 4: read-before-write conflict
        do_cycle(1, 1, 8'h10, 16'h1111, 0, 0, 8'h00, 16'h0);
        do_cycle(1, 0, 8'h10, 16'h0, 1, 1, 8'h10, 16'h2222);
        check("t4_old", 32'(dOutA), 32'h1111);
        check("t4_coll", 32'(collision), 32'h1);
        do_cycle(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
        check("t4_new", 32'(dOutA), 32'h2222);

        // 5: read-read same address, then writes to different addresses
        do_cycle(1, 0, 8'h01, 16'h0, 1, 0, 8'h01, 16'h0);
        check("t5_rr", 32'({dOutA, dOutB}), 32'h0002_0002);
        do_cycle(1, 1, 8'h20, 16'hAAAA, 1, 1, 8'h21, 16'h5555);
        do_cycle(1, 0, 8'h21, 16'h0, 1, 0, 8'h20, 16'h0);
        check("t5_ww", 32'({dOutA, dOutB}), 32'h5555_AAAA);

        // Consecutive conflicting edges keep collision high
        do_cycle(1, 1, 8'h30, 16'h0101, 1, 0, 8'h30, 16'h0);
        do_cycle(1, 0, 8'h31, 16'h0, 1, 1, 8'h31, 16'h0202);

        // 6: asynchronous reset between edges, memory retained
        do_cycle(1, 0, 8'h01, 16'h0, 1, 0, 8'h05, 16'h0);
        EnA = 0; EnB = 0;
        #1;
        rstN = 1'b0;
        #1;
        check("t6_rst_a", 32'(dOutA), 32'h0);
        check("t6_rst_b", 32'(dOutB), 32'h0);
        check("t6_rst_c", 32'(collision), 32'h0);
        exp_a = '0; exp_b = '0;
        @(negedge clk);
        rstN = 1'b1;
        idle();
        do_cycle(1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0);
        check("t6_kept", 32'(dOutA), 32'h0002);

        // Random traffic over a small address window to provoke conflicts
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 3)), DW'($urandom_range(0, 16'hffff)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 3)), DW'($urandom_range(0, 16'hffff)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
